writeback: RTL and testbench
============================

Name: writeback

Overview:
- Final stage of the multi-cycle 8-bit core. Sits directly downstream of the execute stage and consumes its result and result_valid.
- For ALU ops it writes the result into the register file.
- For LW it treats the result as a data-memory address, fetches the word over a req/ack handshake, then writes it back.
- Owns the 2-read/1-write register file used by decode, and signals completion to the control FSM.

Parameters:
NREGS, 32, number of architectural registers (index width 5)
DW, 8, datapath width
TIMEOUT, 16, max cycles waiting for dmem_ack before aborting a load

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
state  in  3  control FSM state; block acts only in `STATE_WB
opcode  in  6  opcode of the instruction in flight
func  in  6  function field
rt  in  5  rt field (destination for ADDIU/LW)
rd  in  5  rd field (destination for R-type)
result  in  8  execute result (ALU value or LW address)
result_valid  in  1  execute produced a writable result
dmem_req  out  1  load request, held until ack
dmem_addr  out  8  load address
dmem_rdata  in  8  load data, valid with dmem_ack
dmem_ack  in  1  load acknowledge, one-cycle pulse
ra_addr  in  5  read port A index (decode rs)
ra_data  out  8  read port A data
rb_addr  in  5  read port B index (decode rt)
rb_data  out  8  read port B data
wb_done  out  1  one-cycle pulse: instruction retired
wb_error  out  1  one-cycle pulse with wb_done: load timed out, no write

Behaviour:
- Reset:
  - All registers 0; FSM in IDLE; armed=1.
  - dmem_req=0, dmem_addr=0, wb_done=0, wb_error=0, timeout counter=0.
  - Reset mid-load drops dmem_req on the next edge; no register write occurs.
- FSM states: IDLE, LOAD_WAIT, DONE.
- IDLE:
  - Accept only when state==`STATE_WB and armed=1. Acceptance clears armed. armed sets again in any cycle where state!=`STATE_WB, so one WB visit retires exactly one instruction.
  - result_valid=0 (branches, unknown ops): no write; go DONE.
  - opcode==`OP_LW and result_valid=1: on the next edge dmem_req=1 and dmem_addr=result; counter cleared; go LOAD_WAIT.
  - Recognised ALU op with result_valid=1: write result to the destination at this edge; go DONE.
    - R-type (ADDU/SUBU/SLT with matching func): destination = rd.
    - ADDIU: destination = rt.
- LOAD_WAIT:
  - dmem_req and dmem_addr are held stable until ack.
  - On dmem_ack=1: write dmem_rdata to rt at that edge; dmem_req=0; go DONE.
  - Counter increments each cycle without ack. When it reaches TIMEOUT-1 with no ack: dmem_req=0, set error flag, no write; go DONE.
  - An ack arriving in the same cycle as the timeout wins (write, no error).
- DONE: wb_done=1 for exactly one cycle (wb_error=1 alongside if flagged); return to IDLE.
- Latency:
  - ALU op: accept at cycle t, register updated at t, wb_done at t+1.
  - Load with ack at cycle t+k: register written at t+k, wb_done at t+k+1.
- Register 0: writes are discarded; reads always return 0.
- Read ports are combinational with write-first bypass. If a write to address X occurs in the same cycle as a read of X (X≠0), the read returns the new data.
- Widths: all data is 8-bit; no sign or zero extension is performed here.
- dmem_ack while not in LOAD_WAIT is ignored.

Decomposition:
- Shared headers state_defs.v, opcode_defs.v, func_defs.v supply `STATE_WB, `OP_*, `FUNC_*. Add `STATE_WB to state_defs.v if absent.
- Local writeback-FSM encodings stay inside this module.
- One sub-module: regfile (NREGS×DW, 2 async read ports, 1 sync write port, r0 hardwired 0, write-first bypass). writeback instantiates it.

Test Plan:
- ADDU, rd=5, result=0x3C, result_valid=1, one WB visit -> r5=0x3C; wb_done pulses once; ra_addr=5 reads 0x3C.
- LW, rt=7, result=0x20; ack 3 cycles after req with rdata=0xA5 -> dmem_req high 3 cycles with addr 0x20 held; r7=0xA5; wb_done 1 cycle after ack; wb_error=0.
- LW with no ack, TIMEOUT=16 -> dmem_req drops after 16 cycles; wb_done and wb_error pulse together; rt is unchanged.
- ADDIU, rt=0, result=0xFF -> r0 reads 0; wb_done pulses. BEQ with result_valid=0 -> no register changes; wb_done pulses.
- state held at `STATE_WB for 5 cycles -> exactly one write and one wb_done. Write r3=0x11 while ra_addr=3 -> ra_data=0x11 in that same cycle.
- rst asserted 2 cycles into LOAD_WAIT, ack arrives afterwards -> dmem_req=0 after the reset edge; all registers 0; no wb_done.

Source files
------------

// File: rtl/writeback_pkg.sv
// writeback_pkg: control-state, opcode and function encodings shared by the writeback stage
package writeback_pkg;
  localparam logic [2:0] STATE_WB = 3'd4;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] FUNC_ADDU = 6'h21;
  localparam logic [5:0] FUNC_SUBU = 6'h23;
  localparam logic [5:0] FUNC_SLT = 6'h2a;
  function automatic logic is_rtype_alu(input logic [5:0] f);
    return f == FUNC_ADDU || f == FUNC_SUBU || f == FUNC_SLT;
  endfunction
endpackage

// File: rtl/writeback_regfile.sv
// writeback_regfile: NREGS x DW regs, r0 reads 0; sync write (we_i/waddr_i/wdata_i), async reads ra/rb with write-first bypass
module writeback_regfile #(
  parameter int NREGS = 32,
  parameter int DW = 8,
  parameter int AW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] ra_addr_i,
  output logic [DW-1:0] ra_data_o,
  input  logic [AW-1:0] rb_addr_i,
  output logic [DW-1:0] rb_data_o
);
  logic [DW-1:0] mem_q [NREGS];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i && waddr_i != '0) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
  assign ra_data_o = ra_addr_i == '0 ? '0 : (we_i && waddr_i == ra_addr_i) ? wdata_i : mem_q[ra_addr_i];
  assign rb_data_o = rb_addr_i == '0 ? '0 : (we_i && waddr_i == rb_addr_i) ? wdata_i : mem_q[rb_addr_i];
endmodule

// File: rtl/writeback.sv
// writeback: retires one instruction per WB visit (ALU write or LW via dmem req/ack with timeout), owns regfile, pulses wb_done/wb_error
module writeback
  import writeback_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int DW = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    state,
  input  logic [5:0]    opcode,
  input  logic [5:0]    func,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [DW-1:0] result,
  input  logic          result_valid,
  output logic          dmem_req,
  output logic [DW-1:0] dmem_addr,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  input  logic [4:0]    ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [4:0]    rb_addr,
  output logic [DW-1:0] rb_data,
  output logic          wb_done,
  output logic          wb_error
);
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, DONE} fsm_e;
  localparam int CW = $clog2(TIMEOUT);
  fsm_e fsm_q, fsm_d;
  logic armed_q, armed_d, req_q, req_d, err_q, err_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0] dst_q, dst_d;
  logic accept, alu_op, we;
  logic [4:0] waddr;
  logic [DW-1:0] wdata;
  assign accept = fsm_q == IDLE && state == STATE_WB && armed_q;
  assign alu_op = (opcode == OP_RTYPE && is_rtype_alu(func)) || opcode == OP_ADDIU;
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      armed_q <= 1'b1;
      req_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      cnt_q <= '0;
      dst_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      armed_q <= armed_d;
      req_q <= req_d;
      err_q <= err_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      dst_q <= dst_d;
    end
  end
  always_comb begin
    fsm_d = fsm_q;
    armed_d = state != STATE_WB || (armed_q && !accept);
    req_d = req_q;
    err_d = err_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    dst_d = dst_q;
    case (fsm_q)
      IDLE: if (accept) begin
        err_d = 1'b0;
        fsm_d = DONE;
        if (opcode == OP_LW && result_valid) begin
          fsm_d = LOAD_WAIT;
          req_d = 1'b1;
          addr_d = result;
          cnt_d = '0;
          dst_d = rt;
        end
      end
      // an ack in the final timeout cycle still counts as a successful load
      LOAD_WAIT: if (dmem_ack || cnt_q == CW'(TIMEOUT - 1)) begin
        fsm_d = DONE;
        req_d = 1'b0;
        err_d = !dmem_ack;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: begin
        fsm_d = IDLE;
        err_d = 1'b0;
      end
    endcase
  end
  always_comb begin
    we = (accept && result_valid && alu_op) || (fsm_q == LOAD_WAIT && dmem_ack);
    waddr = fsm_q == LOAD_WAIT ? dst_q : opcode == OP_RTYPE ? rd : rt;
    wdata = fsm_q == LOAD_WAIT ? dmem_rdata : result;
    wb_done = fsm_q == DONE;
    wb_error = fsm_q == DONE && err_q;
  end
  assign dmem_req = req_q;
  assign dmem_addr = addr_q;
  writeback_regfile #(.NREGS(NREGS), .DW(DW)) u_regfile (
    .clk(clk),
    .rst(rst),
    .we_i(we),
    .waddr_i(waddr),
    .wdata_i(wdata),
    .ra_addr_i(ra_addr),
    .ra_data_o(ra_data),
    .rb_addr_i(rb_addr),
    .rb_data_o(rb_data)
  );
endmodule

// File: tb/tb_writeback.sv
// tb_writeback: randomized transactions against a cycle-level behavioural model plus literal checks of the directed scenarios
module tb_writeback;
  import writeback_pkg::*;
  localparam int TMO = 16;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] state;
  logic [5:0] opcode, func;
  logic [4:0] rt, rd, ra_addr, rb_addr;
  logic [7:0] result, dmem_rdata, dmem_addr, ra_data, rb_data;
  logic result_valid, dmem_ack, dmem_req, wb_done, wb_error;
  always #5 clk = ~clk;
  writeback dut (
    .clk(clk), .rst(rst), .state(state), .opcode(opcode), .func(func), .rt(rt), .rd(rd),
    .result(result), .result_valid(result_valid), .dmem_req(dmem_req), .dmem_addr(dmem_addr),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .ra_addr(ra_addr), .ra_data(ra_data),
    .rb_addr(rb_addr), .rb_data(rb_data), .wb_done(wb_done), .wb_error(wb_error)
  );
  int errors = 0, checks = 0;
  int req_cycles = 0, done_pulses = 0, err_pulses = 0;
  logic [7:0] mregs [32];
  logic e_req, e_done, e_err, e_we;
  logic [7:0] e_addr, e_wdata;
  logic [4:0] e_waddr;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] mread(input logic [4:0] a);
    if (a == 0) return 8'h00;
    if (e_we && e_waddr == a) return e_wdata;
    return mregs[a];
  endfunction
  task automatic step();
    @(negedge clk);
    check("dmem_req", dmem_req, e_req);
    if (e_req) check("dmem_addr", dmem_addr, e_addr);
    check("wb_done", wb_done, e_done);
    check("wb_error", wb_error, e_err);
    check("ra_data", ra_data, mread(ra_addr));
    check("rb_data", rb_data, mread(rb_addr));
    if (dmem_req === 1'b1) req_cycles++;
    if (wb_done === 1'b1) done_pulses++;
    if (wb_error === 1'b1) err_pulses++;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 8'h00;
    end else if (e_we && e_waddr != 0) begin
      mregs[e_waddr] = e_wdata;
    end
    #1;
  endtask
  task automatic misc(input bit allow_ack);
    ra_addr = 5'($urandom_range(0, 7));
    rb_addr = 5'($urandom_range(0, 7));
    dmem_ack = allow_ack && ($urandom_range(0, 3) == 0);
    dmem_rdata = 8'($urandom);
  endtask
  task automatic clear_exp();
    e_req = 0; e_done = 0; e_err = 0; e_we = 0;
  endtask
  task automatic op(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] t, input logic [4:0] d,
                    input logic [7:0] res, input logic v, input int hold, input int ack_at,
                    input logic [7:0] rdat, input bit pin, input logic [7:0] pexp);
    logic is_alu, acked;
    clear_exp();
    state = 3'($urandom_range(0, 3));
    misc(1);
    step();
    state = STATE_WB; opcode = opc; func = fn; rt = t; rd = d; result = res; result_valid = v;
    is_alu = (opc == OP_RTYPE && (fn == FUNC_ADDU || fn == FUNC_SUBU || fn == FUNC_SLT)) || opc == OP_ADDIU;
    e_we = v && is_alu; e_waddr = opc == OP_RTYPE ? d : t; e_wdata = res;
    misc(1);
    if (pin) begin
      ra_addr = e_waddr;
      #1;
      check("bypass", ra_data, pexp);
    end
    step();
    e_we = 0;
    acked = 0;
    if (v && opc == OP_LW) begin
      for (int j = 0; j < TMO && !acked; j++) begin
        e_req = 1; e_addr = res;
        acked = (j == ack_at);
        misc(0);
        dmem_ack = acked;
        if (acked) dmem_rdata = rdat;
        e_we = acked; e_waddr = t; e_wdata = rdat;
        step();
      end
      e_req = 0; e_we = 0;
    end
    e_done = 1; e_err = v && opc == OP_LW && !acked;
    misc(1);
    step();
    e_done = 0; e_err = 0;
    repeat (hold) begin misc(1); step(); end
  endtask
  task automatic lit(input string n, input logic [4:0] a, input logic [7:0] x);
    clear_exp();
    state = 3'd1; dmem_ack = 0; ra_addr = a; rb_addr = a;
    #1;
    check(n, ra_data, x);
    step();
  endtask
  initial begin
    int d0, r0, e0;
    logic [5:0] ro, rf;
    for (int i = 0; i < 32; i++) mregs[i] = 8'h00;
    rst = 1; state = 0; opcode = 0; func = 0; rt = 0; rd = 0; result = 0; result_valid = 0;
    dmem_ack = 0; dmem_rdata = 0; ra_addr = 0; rb_addr = 0;
    clear_exp(); e_addr = 0; e_waddr = 0; e_wdata = 0;
    @(posedge clk); #1;
    check("reset_addr", dmem_addr, 8'h00);
    step();
    rst = 0;
    d0 = done_pulses;
    op(OP_RTYPE, FUNC_ADDU, 5'd0, 5'd5, 8'h3C, 1, 0, 0, 8'h00, 0, 8'h00);
    check("addu_done_count", done_pulses - d0, 1);
    lit("addu_r5", 5'd5, 8'h3C);
    d0 = done_pulses; r0 = req_cycles; e0 = err_pulses;
    op(OP_LW, 6'h00, 5'd7, 5'd0, 8'h20, 1, 0, 2, 8'hA5, 0, 8'h00);
    check("lw_req_cycles", req_cycles - r0, 3);
    check("lw_done_count", done_pulses - d0, 1);
    check("lw_err_count", err_pulses - e0, 0);
    lit("lw_r7", 5'd7, 8'hA5);
    d0 = done_pulses; r0 = req_cycles; e0 = err_pulses;
    op(OP_LW, 6'h00, 5'd7, 5'd0, 8'h44, 1, 0, 99, 8'h00, 0, 8'h00);
    check("tmo_req_cycles", req_cycles - r0, 16);
    check("tmo_done_count", done_pulses - d0, 1);
    check("tmo_err_count", err_pulses - e0, 1);
    lit("tmo_r7_kept", 5'd7, 8'hA5);
    d0 = done_pulses;
    op(OP_ADDIU, 6'h00, 5'd0, 5'd0, 8'hFF, 1, 0, 0, 8'h00, 0, 8'h00);
    lit("addiu_r0", 5'd0, 8'h00);
    op(OP_BEQ, 6'h00, 5'd5, 5'd5, 8'h99, 0, 0, 0, 8'h00, 0, 8'h00);
    check("addiu_beq_done_count", done_pulses - d0, 2);
    lit("beq_r5_kept", 5'd5, 8'h3C);
    d0 = done_pulses;
    op(OP_RTYPE, FUNC_SUBU, 5'd0, 5'd3, 8'h11, 1, 3, 0, 8'h00, 1, 8'h11);
    check("hold5_done_count", done_pulses - d0, 1);
    lit("hold5_r3", 5'd3, 8'h11);
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 4))
        0: ro = OP_RTYPE;
        1: ro = OP_ADDIU;
        2: ro = OP_LW;
        3: ro = OP_BEQ;
        default: ro = 6'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: rf = FUNC_ADDU;
        1: rf = FUNC_SUBU;
        2: rf = FUNC_SLT;
        default: rf = 6'($urandom);
      endcase
      op(ro, rf, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 8'($urandom),
         $urandom_range(0, 4) != 0, $urandom_range(0, 2), $urandom_range(0, 17), 8'($urandom), 0, 8'h00);
    end
    op(OP_RTYPE, FUNC_ADDU, 5'd0, 5'd5, 8'h3C, 1, 0, 0, 8'h00, 0, 8'h00);
    clear_exp();
    state = 3'd1; misc(1); step();
    state = STATE_WB; opcode = OP_LW; func = 0; rt = 5'd9; rd = 0; result = 8'h40; result_valid = 1;
    misc(1); step();
    repeat (2) begin e_req = 1; e_addr = 8'h40; misc(0); step(); end
    rst = 1; misc(0); step();
    rst = 0; state = 3'd1; clear_exp();
    check("rst_req_dropped", dmem_req, 1'b0);
    d0 = done_pulses;
    misc(0); dmem_ack = 1; dmem_rdata = 8'h77; step();
    repeat (3) begin misc(0); step(); end
    check("rst_no_done", done_pulses - d0, 0);
    lit("rst_r5", 5'd5, 8'h00);
    lit("rst_r9", 5'd9, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
